// File: rtl/lcd_bus_pkg.sv
// Shared types and default timing for the 8080-style LCD bus sequencer.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    StRstLow,
    StRstWait,
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  localparam int unsigned DefWrLowCyc   = 2;
  localparam int unsigned DefWrHighCyc  = 2;
  localparam int unsigned DefRdLowCyc   = 8;
  localparam int unsigned DefRdHighCyc  = 4;
  localparam int unsigned DefRstLowCyc  = 500000;
  localparam int unsigned DefRstWaitCyc = 2500000;

  localparam int unsigned BlCntW = 8;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running 8-bit counter, duty shadowed at the wrap so edits never glitch.
module lcd_bl_pwm
  import lcd_bus_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BlCntW-1:0] duty_i,
  output logic              pwm_o
);

  logic [BlCntW-1:0] cnt_q, cnt_d;
  logic [BlCntW-1:0] duty_q, duty_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    duty_d = (cnt_q == '1) ? duty_i : duty_q;
  end

  // Compare next-state values so pwm_o lines up with the counter value it reflects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_o  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_o  <= (cnt_d < duty_d);
    end
  end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// 16-bit 8080-style TFT LCD bus sequencer with panel reset sequencing and backlight PWM.
module lcd_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC   = DefWrLowCyc,
  parameter int unsigned WR_HIGH_CYC  = DefWrHighCyc,
  parameter int unsigned RD_LOW_CYC   = DefRdLowCyc,
  parameter int unsigned RD_HIGH_CYC  = DefRdHighCyc,
  parameter int unsigned RST_LOW_CYC  = DefRstLowCyc,
  parameter int unsigned RST_WAIT_CYC = DefRstWaitCyc
) (
  input  logic        CLK_50,
  input  logic        RESET,
  input  logic        soft_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rs,
  input  logic        cmd_read,
  input  logic [15:0] cmd_wdata,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        init_done,
  output logic        busy,
  input  logic [7:0]  bl_duty,
  output logic        bl_pwm,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic        lcd_rst_n,
  output logic [15:0] lcd_data_o,
  output logic        lcd_data_oe,
  input  logic [15:0] lcd_data_i
);

  localparam int unsigned MaxCyc = max2(max2(max2(WR_LOW_CYC, WR_HIGH_CYC),
                                             max2(RD_LOW_CYC, RD_HIGH_CYC)),
                                        max2(RST_LOW_CYC, RST_WAIT_CYC));
  localparam int unsigned CntW = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] WrLowLd   = CntW'(WR_LOW_CYC - 1);
  localparam logic [CntW-1:0] WrHighLd  = CntW'(WR_HIGH_CYC - 1);
  localparam logic [CntW-1:0] RdLowLd   = CntW'(RD_LOW_CYC - 1);
  localparam logic [CntW-1:0] RdHighLd  = CntW'(RD_HIGH_CYC - 1);
  localparam logic [CntW-1:0] RstLowLd  = CntW'(RST_LOW_CYC - 1);
  localparam logic [CntW-1:0] RstWaitLd = CntW'(RST_WAIT_CYC - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            read_q;

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q     <= StRstLow;
      cnt_q       <= RstLowLd;
      read_q      <= 1'b0;
      cmd_ready   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      init_done   <= 1'b0;
      busy        <= 1'b1;
      lcd_cs_n    <= 1'b1;
      lcd_rs      <= 1'b1;
      lcd_wr_n    <= 1'b1;
      lcd_rd_n    <= 1'b1;
      lcd_rst_n   <= 1'b0;
      lcd_data_o  <= '0;
      lcd_data_oe <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      unique case (state_q)
        StRstLow: begin
          if (cnt_q == '0) begin
            state_q   <= StRstWait;
            cnt_q     <= RstWaitLd;
            lcd_rst_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRstWait: begin
          if (cnt_q == '0) begin
            state_q   <= StIdle;
            init_done <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StIdle: begin
          // soft_rst wins over a simultaneous request.
          if (soft_rst) begin
            state_q   <= StRstLow;
            cnt_q     <= RstLowLd;
            lcd_rst_n <= 1'b0;
            init_done <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (cmd_valid && cmd_ready) begin
            state_q     <= StSetup;
            cnt_q       <= '0;
            read_q      <= cmd_read;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            lcd_cs_n    <= 1'b0;
            lcd_rs      <= cmd_rs;
            lcd_data_oe <= ~cmd_read;
            if (!cmd_read) lcd_data_o <= cmd_wdata;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q <= StStrobe;
            if (read_q) begin
              lcd_rd_n <= 1'b0;
              cnt_q    <= RdLowLd;
            end else begin
              lcd_wr_n <= 1'b0;
              cnt_q    <= WrLowLd;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStrobe: begin
          if (cnt_q == '0) begin
            state_q  <= StHold;
            lcd_wr_n <= 1'b1;
            lcd_rd_n <= 1'b1;
            if (read_q) begin
              // Sampled on the last low cycle, presented with the first hold cycle.
              rdata       <= lcd_data_i;
              rdata_valid <= 1'b1;
              cnt_q       <= RdHighLd;
            end else begin
              cnt_q <= WrHighLd;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q     <= StIdle;
            lcd_cs_n    <= 1'b1;
            lcd_data_oe <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StRstLow;
          cnt_q   <= RstLowLd;
        end
      endcase
    end
  end

  lcd_bl_pwm u_bl_pwm (
    .clk_i  (CLK_50),
    .rst_i  (RESET),
    .duty_i (bl_duty),
    .pwm_o  (bl_pwm)
  );

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl: transaction vector table plus reset and PWM sequences.
module tb_lcd_bus_ctrl;

  logic        CLK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        soft_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rs = 1'b0;
  logic        cmd_read = 1'b0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        init_done;
  logic        busy;
  logic [7:0]  bl_duty = 8'd0;
  logic        bl_pwm;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n;
  logic [15:0] lcd_data_o;
  logic        lcd_data_oe;
  logic [15:0] lcd_data_i = 16'h0000;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rs;
    logic        read;
    logic [15:0] wdata;
    logic [15:0] din;
    int          exp_cs;
    int          exp_lo;
    int          exp_vk;
  } vec_t;

  vec_t vecs[5];

  lcd_bus_ctrl #(
    .RST_LOW_CYC  (10),
    .RST_WAIT_CYC (20)
  ) dut (
    .CLK_50      (CLK_50),
    .RESET       (RESET),
    .soft_rst    (soft_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rs      (cmd_rs),
    .cmd_read    (cmd_read),
    .cmd_wdata   (cmd_wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .init_done   (init_done),
    .busy        (busy),
    .bl_duty     (bl_duty),
    .bl_pwm      (bl_pwm),
    .lcd_cs_n    (lcd_cs_n),
    .lcd_rs      (lcd_rs),
    .lcd_wr_n    (lcd_wr_n),
    .lcd_rd_n    (lcd_rd_n),
    .lcd_rst_n   (lcd_rst_n),
    .lcd_data_o  (lcd_data_o),
    .lcd_data_oe (lcd_data_oe),
    .lcd_data_i  (lcd_data_i)
  );

  always #5 CLK_50 = ~CLK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Counts lcd_rst_n low samples then high samples before init_done, from the current sample.
  task automatic measure_reset(input string tag);
    int lo;
    int hi;
    lo = 0;
    hi = 0;
    for (int i = 0; i < 100 && lcd_rst_n === 1'b0; i++) begin
      lo++;
      @(negedge CLK_50);
    end
    for (int i = 0; i < 100 && lcd_rst_n === 1'b1 && init_done === 1'b0; i++) begin
      hi++;
      @(negedge CLK_50);
    end
    check({tag, " rst_low_cycles"}, lo, 10);
    check({tag, " rst_wait_cycles"}, hi, 20);
    check({tag, " init_done"}, init_done, 1);
    check({tag, " cmd_ready"}, cmd_ready, 1);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && cmd_ready !== 1'b1; i++) @(negedge CLK_50);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int cs_lo, lo, first, vcnt, vk, bad_oe, bad_both, bad_rs, bad_dat;
    logic [15:0] rd;
    logic strobe, other;
    string tag;
    cs_lo = 0; lo = 0; first = -1; vcnt = 0; vk = -1;
    bad_oe = 0; bad_both = 0; bad_rs = 0; bad_dat = 0; rd = 16'h0;
    tag = $sformatf("v%0d", idx);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_rs = v.rs;
    cmd_read = v.read;
    cmd_wdata = v.wdata;
    lcd_data_i = v.din;
    @(negedge CLK_50);
    cmd_valid = 1'b0;
    check({tag, " busy_in_txn"}, busy, 1);
    check({tag, " ready_in_txn"}, cmd_ready, 0);
    for (int k = 0; k < 40; k++) begin
      if (lcd_cs_n !== 1'b0) break;
      cs_lo++;
      strobe = v.read ? lcd_rd_n : lcd_wr_n;
      other = v.read ? lcd_wr_n : lcd_rd_n;
      if (strobe === 1'b0) begin
        lo++;
        if (first < 0) first = k;
      end
      if (other !== 1'b1) bad_both++;
      if (lcd_rd_n === 1'b0 && lcd_data_oe !== 1'b0) bad_oe++;
      if (lcd_rs !== v.rs) bad_rs++;
      if (!v.read && (lcd_data_oe !== 1'b1 || lcd_data_o !== v.wdata)) bad_dat++;
      if (v.read && lcd_data_oe !== 1'b0) bad_dat++;
      if (rdata_valid === 1'b1) begin
        vcnt++;
        vk = k;
        rd = rdata;
      end
      @(negedge CLK_50);
    end
    check({tag, " cs_low_cycles"}, cs_lo, v.exp_cs);
    check({tag, " strobe_low_cycles"}, lo, v.exp_lo);
    check({tag, " strobe_start"}, first, 1);
    check({tag, " other_strobe_high"}, bad_both, 0);
    check({tag, " oe_during_rd"}, bad_oe, 0);
    check({tag, " rs_level"}, bad_rs, 0);
    check({tag, " data_drive"}, bad_dat, 0);
    check({tag, " rvalid_count"}, vcnt, v.read ? 1 : 0);
    check({tag, " rvalid_cycle"}, vk, v.exp_vk);
    if (v.read) check({tag, " rdata"}, rd, v.din);
    else check({tag, " data_kept"}, lcd_data_o, v.wdata);
    check({tag, " end_oe"}, lcd_data_oe, 0);
    check({tag, " end_ready"}, cmd_ready, 1);
    check({tag, " end_busy"}, busy, 0);
    check({tag, " end_rvalid"}, rdata_valid, 0);
  endtask

  initial begin
    int falls, k2, cs_hi;
    int h1, h2, r1, r2;
    logic prev;

    vecs[0] = '{rs: 1'b0, read: 1'b0, wdata: 16'h0022, din: 16'h0000,
                exp_cs: 5, exp_lo: 2, exp_vk: -1};
    vecs[1] = '{rs: 1'b1, read: 1'b0, wdata: 16'hF800, din: 16'h0000,
                exp_cs: 5, exp_lo: 2, exp_vk: -1};
    vecs[2] = '{rs: 1'b1, read: 1'b1, wdata: 16'h0000, din: 16'h9325,
                exp_cs: 13, exp_lo: 8, exp_vk: 9};
    vecs[3] = '{rs: 1'b0, read: 1'b1, wdata: 16'h1234, din: 16'hA5A5,
                exp_cs: 13, exp_lo: 8, exp_vk: 9};
    vecs[4] = '{rs: 1'b1, read: 1'b0, wdata: 16'hFFFF, din: 16'h5A5A,
                exp_cs: 5, exp_lo: 2, exp_vk: -1};

    // Reset values and power-on reset sequence.
    repeat (3) @(negedge CLK_50);
    check("rst cs_n", lcd_cs_n, 1);
    check("rst rs", lcd_rs, 1);
    check("rst wr_n", lcd_wr_n, 1);
    check("rst rd_n", lcd_rd_n, 1);
    check("rst lcd_rst_n", lcd_rst_n, 0);
    check("rst data_o", lcd_data_o, 0);
    check("rst oe", lcd_data_oe, 0);
    check("rst cmd_ready", cmd_ready, 0);
    check("rst rdata", rdata, 0);
    check("rst rdata_valid", rdata_valid, 0);
    check("rst init_done", init_done, 0);
    check("rst busy", busy, 1);
    check("rst bl_pwm", bl_pwm, 0);
    RESET = 1'b0;
    measure_reset("por");

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

    // Back-to-back writes with cmd_valid held high.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_rs = 1'b1;
    cmd_read = 1'b0;
    cmd_wdata = 16'hF800;
    @(negedge CLK_50);
    check("b2b first data", lcd_data_o, 16'hF800);
    cmd_wdata = 16'h07E0;
    falls = 0;
    k2 = -1;
    cs_hi = 0;
    prev = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(negedge CLK_50);
      if (lcd_cs_n === 1'b1) cs_hi++;
      if (lcd_cs_n === 1'b0 && prev === 1'b1) begin
        k2 = k;
        cmd_valid = 1'b0;
        check("b2b second data", lcd_data_o, 16'h07E0);
        break;
      end
      prev = lcd_cs_n;
    end
    cmd_valid = 1'b0;
    check("b2b second fall", k2, 6);
    check("b2b cs_high_gap", cs_hi, 1);

    // soft_rst during a transaction is ignored.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_read = 1'b0;
    cmd_wdata = 16'h1111;
    @(negedge CLK_50);
    cmd_valid = 1'b0;
    soft_rst = 1'b1;
    @(negedge CLK_50);
    soft_rst = 1'b0;
    wait_ready();
    check("busy soft_rst init_done", init_done, 1);
    check("busy soft_rst lcd_rst_n", lcd_rst_n, 1);
    check("busy soft_rst ready", cmd_ready, 1);

    // RESET mid-STROBE of a write.
    cmd_valid = 1'b1;
    cmd_wdata = 16'h4242;
    @(negedge CLK_50);
    cmd_valid = 1'b0;
    @(negedge CLK_50);
    check("midrst strobe_active", lcd_wr_n, 0);
    RESET = 1'b1;
    @(negedge CLK_50);
    RESET = 1'b0;
    check("midrst wr_n", lcd_wr_n, 1);
    check("midrst cs_n", lcd_cs_n, 1);
    check("midrst oe", lcd_data_oe, 0);
    check("midrst lcd_rst_n", lcd_rst_n, 0);
    check("midrst init_done", init_done, 0);
    check("midrst rdata_valid", rdata_valid, 0);
    measure_reset("midrst");

    // soft_rst and cmd_valid together in IDLE.
    wait_ready();
    soft_rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_wdata = 16'hBEEF;
    @(negedge CLK_50);
    soft_rst = 1'b0;
    cmd_valid = 1'b0;
    check("soft cmd_ready", cmd_ready, 0);
    check("soft init_done", init_done, 0);
    check("soft cs_n", lcd_cs_n, 1);
    check("soft busy", busy, 1);
    measure_reset("soft");

    // Backlight: duty 64, then 192 written mid-period.
    bl_duty = 8'd64;
    repeat (300) @(negedge CLK_50);
    prev = bl_pwm;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK_50);
      if (bl_pwm === 1'b1 && prev === 1'b0) break;
      prev = bl_pwm;
    end
    h1 = 0; h2 = 0; r1 = 0; r2 = 0;
    prev = 1'b0;
    for (int k = 0; k < 512; k++) begin
      if (k == 100) bl_duty = 8'd192;
      if (bl_pwm === 1'b1) begin
        if (k < 256) h1++;
        else h2++;
        if (prev === 1'b0) begin
          if (k < 256) r1++;
          else r2++;
        end
      end
      prev = bl_pwm;
      @(negedge CLK_50);
    end
    check("pwm64 highs", h1, 64);
    check("pwm64 pulses", r1, 1);
    check("pwm192 highs", h2, 192);
    check("pwm192 pulses", r2, 1);

    bl_duty = 8'd0;
    repeat (300) @(negedge CLK_50);
    h1 = 0;
    for (int k = 0; k < 256; k++) begin
      if (bl_pwm !== 1'b0) h1++;
      @(negedge CLK_50);
    end
    check("pwm0 highs", h1, 0);

    bl_duty = 8'd255;
    repeat (300) @(negedge CLK_50);
    h1 = 0;
    for (int k = 0; k < 256; k++) begin
      if (bl_pwm === 1'b1) h1++;
      @(negedge CLK_50);
    end
    check("pwm255 highs", h1, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_ctrl.md
Name: lcd_bus_ctrl

Overview:
- Hardware sequencer for the 16-bit 8080-style parallel TFT LCD bus: CS, RS, WR, RD, RESET and DATA[15:0] on the GPIO header.
- Replaces CPU bit-banging of the LCD PIO lines. The Nios side pushes command/data words through a valid/ready port and receives read data through a one-cycle valid pulse.
- Also performs the panel hardware-reset sequence and generates the glitch-free backlight PWM.

Parameters:
- WR_LOW_CYC, 2, cycles WR_n is held low per write (≥1)
- WR_HIGH_CYC, 2, cycles WR_n is held high after the strobe, with CS_n still low (≥1)
- RD_LOW_CYC, 8, cycles RD_n is held low per read (≥1)
- RD_HIGH_CYC, 4, cycles RD_n is held high after the read strobe (≥1)
- RST_LOW_CYC, 500000, cycles lcd_rst_n is held low (10 ms at 50 MHz)
- RST_WAIT_CYC, 2500000, wait after reset release before init_done (50 ms)

Ports:
- CLK_50  in  1  system clock, 50 MHz
- RESET  in  1  synchronous reset, active-high
- soft_rst  in  1  pulse: rerun the panel reset sequence (honoured in IDLE only)
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
- cmd_rs  in  1  0 = command/index, 1 = data (drives RS)
- cmd_read  in  1  1 = bus read, 0 = bus write
- cmd_wdata  in  16  write word
- rdata  out  16  read word
- rdata_valid  out  1  one-cycle pulse: rdata is valid
- init_done  out  1  high once the panel reset sequence has completed
- busy  out  1  high whenever state != IDLE
- bl_duty  in  8  backlight duty, 0..255
- bl_pwm  out  1  backlight PWM output
- lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n  out  1 each  panel control pins
- lcd_data_o  out  16  bus drive value
- lcd_data_oe  out  1  bus output enable (the top level builds the tristate)
- lcd_data_i  in  16  bus sample

Behaviour:
- Clocking and reset:
  - Single clock domain; RESET is synchronous and active-high. All outputs are registered.
  - Reset values: lcd_cs_n=1, lcd_rs=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rst_n=0, lcd_data_o=0, lcd_data_oe=0, cmd_ready=0, rdata=0, rdata_valid=0, init_done=0, busy=1, bl_pwm=0.
- States: RST_LOW -> RST_WAIT -> IDLE -> SETUP -> STROBE -> HOLD -> IDLE. RESET forces RST_LOW from any state, including mid-transaction; the bus returns to its idle levels on the next edge.
- RST_LOW:
  - lcd_rst_n=0 for RST_LOW_CYC cycles.
- RST_WAIT:
  - lcd_rst_n=1 for RST_WAIT_CYC cycles.
  - Then enter IDLE and set init_done=1; it stays high until the next RESET or soft_rst.
- IDLE:
  - cmd_ready=1 exactly when state=IDLE and init_done=1.
  - soft_rst takes priority over cmd_valid in the same cycle: clear init_done, go to RST_LOW, cmd_ready=0. soft_rst outside IDLE is ignored.
  - On accept, latch rs, read and wdata, then go to SETUP. cmd_ready drops in the cycle after the handshake.
- SETUP (1 cycle):
  - lcd_cs_n=0, lcd_rs=latched rs.
  - Write: lcd_data_o=wdata, lcd_data_oe=1. Read: lcd_data_oe=0.
- STROBE:
  - Write: lcd_wr_n=0 for WR_LOW_CYC cycles.
  - Read: lcd_rd_n=0 for RD_LOW_CYC cycles; capture lcd_data_i into rdata on the last low cycle.
- HOLD:
  - Strobe back high; CS_n, RS and data unchanged.
  - Lasts WR_HIGH_CYC (write) or RD_HIGH_CYC (read) cycles.
  - Read only: rdata_valid pulses in the first HOLD cycle.
  - Exit to IDLE: lcd_cs_n=1, lcd_data_oe=0. lcd_data_o keeps its last value.
- Occupancy and throughput:
  - Write: 1 + WR_LOW_CYC + WR_HIGH_CYC cycles, plus 1 IDLE cycle → back-to-back throughput of one word per 6 cycles at defaults.
  - Read: 1 + RD_LOW_CYC + RD_HIGH_CYC cycles.
  - CS_n always goes high between transactions.
- Invariants: WR_n and RD_n are never low simultaneously; lcd_data_oe=0 whenever lcd_rd_n=0.
- Phase counter:
  - Width = clog2 of the largest parameter.
  - Loads (N-1) on state entry and advances when it reaches 0.
- Backlight PWM:
  - 8-bit free-running counter, running from reset, independent of the FSM.
  - bl_pwm = (cnt < duty_q).
  - duty_q samples bl_duty only on the cycle cnt wraps 255->0. duty 0 gives a constant low; duty 255 gives high 255 of every 256 cycles.
  - duty_q resets to 0.

Decomposition:
- Package lcd_bus_pkg holds the state enum (RST_LOW, RST_WAIT, IDLE, SETUP, STROBE, HOLD) and the default timing constants.
- One sub-module: lcd_bl_pwm (counter, duty shadow register, comparator), instantiated once.

Test Plan:
- Reset then wait (RST_LOW_CYC=10, RST_WAIT_CYC=20 for simulation) -> lcd_rst_n low for exactly 10 cycles, high 20 cycles; init_done and cmd_ready rise together on cycle 31.
- Write rs=0, wdata=16'h0022 -> CS_n low 5 cycles; WR_n low 2 cycles starting 1 cycle after CS_n falls; lcd_data_o=0022 with oe=1 throughout; RS=0.
- Two back-to-back data writes 16'hF800, 16'h07E0 with cmd_valid held -> second CS_n falling edge exactly 6 cycles after the first; CS_n high for 1 cycle between them.
- Read rs=1 with lcd_data_i=16'h9325 -> RD_n low 8 cycles, oe=0; rdata=9325 with rdata_valid pulsing once, on the first HOLD cycle.
- RESET asserted mid-STROBE of a write -> next edge: WR_n=1, CS_n=1, oe=0, lcd_rst_n=0, init_done=0; no spurious rdata_valid. soft_rst and cmd_valid together in IDLE -> reset sequence runs and the command is not accepted.
- bl_duty=64 -> bl_pwm high 64 of every 256 cycles. Change bl_duty to 192 mid-period -> the new duty applies only from the next wrap, with no glitch; bl_duty=0 -> bl_pwm constant 0.
